// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive control path
// Purpose : strobe FSM state type, status bit map and divider floor.
// Ports   : none (package).
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HALF = 2'd1,
      ST_BIT  = 2'd2
   } rx_strb_state_t;

   localparam int STAT_WIDTH     = 7;
   localparam int STAT_NOT_EMPTY = 0;
   localparam int STAT_FULL      = 1;
   localparam int STAT_TIMEOUT   = 2;
   localparam int STAT_PARITY    = 3;
   localparam int STAT_FRAME     = 4;
   localparam int STAT_OVERFLOW  = 5;
   localparam int STAT_UNDERFLOW = 6;

   // Bits 2..6 are sticky; bits 0..1 follow the FIFO flags.
   localparam logic [STAT_WIDTH-1:0] STAT_STICKY_MASK = 7'b111_1100;

   localparam int MIN_BAUD_DIV = 3;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - receiver/register-block signal bundle for uart_rx_ctrl
// Purpose : groups every non-clock/reset signal of uart_rx_ctrl.
// Ports   : none; modport slave = control block view, master = driver view
//           (receiver + register block, or testbench).
interface uart_rx_ctrl_if #(
   parameter int DIV_WIDTH     = 16,
   parameter int TIMEOUT_WIDTH = 8
);
   logic                     i_enable;
   logic [DIV_WIDTH-1:0]     i_baud_div;
   logic [TIMEOUT_WIDTH-1:0] i_timeout;
   logic                     i_rx_strb_en;
   logic                     o_rx_strb;
   logic                     i_fifo_empty;
   logic                     i_fifo_full;
   logic                     i_fifo_rd_en;
   logic                     i_parity_error;
   logic                     i_frame_error;
   logic                     i_overflow_error;
   logic                     i_underflow_error;
   logic [6:0]               i_status_clr;
   logic [6:0]               i_irq_mask;
   logic [6:0]               o_status;
   logic                     o_irq;

   modport slave (
      input  i_enable, i_baud_div, i_timeout, i_rx_strb_en,
      input  i_fifo_empty, i_fifo_full, i_fifo_rd_en,
      input  i_parity_error, i_frame_error, i_overflow_error, i_underflow_error,
      input  i_status_clr, i_irq_mask,
      output o_rx_strb, o_status, o_irq
   );

   modport master (
      output i_enable, i_baud_div, i_timeout, i_rx_strb_en,
      output i_fifo_empty, i_fifo_full, i_fifo_rd_en,
      output i_parity_error, i_frame_error, i_overflow_error, i_underflow_error,
      output i_status_clr, i_irq_mask,
      input  o_rx_strb, o_status, o_irq
   );

endinterface

// File: rtl/uart_baud_strobe.sv
// rtl/uart_baud_strobe.sv - mid-bit sample strobe generator and idle bit tick
// Purpose : IDLE/HALF/BIT FSM producing a centred sample strobe per bit while a
//           frame is requested, and a free-running bit tick while idle.
// Ports   : clk, rst (async, active-high); i_enable, i_baud_div, i_rx_strb_en in;
//           o_rx_strb (one-cycle strobe), o_bit_tick (idle bit period tick) out.
module uart_baud_strobe
   import uart_pkg::*;
#(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_enable,
   input  logic [DIV_WIDTH-1:0] i_baud_div,
   input  logic                 i_rx_strb_en,
   output logic                 o_rx_strb,
   output logic                 o_bit_tick
);

   rx_strb_state_t       r_state, w_state_nxt;
   logic [DIV_WIDTH-1:0] r_cnt, w_cnt_nxt;
   logic [DIV_WIDTH-1:0] r_div, w_div_nxt;
   logic [DIV_WIDTH-1:0] w_div_live;
   logic                 w_run;

   assign w_div_live = (i_baud_div < DIV_WIDTH'(MIN_BAUD_DIV)) ? DIV_WIDTH'(MIN_BAUD_DIV)
                                                               : i_baud_div;
   assign w_run      = i_enable & i_rx_strb_en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_div   <= DIV_WIDTH'(MIN_BAUD_DIV);
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_div   <= w_div_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_div_nxt   = r_div;
      o_rx_strb   = 1'b0;
      o_bit_tick  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!i_enable) begin
               w_cnt_nxt = '0;
            end else if (i_rx_strb_en) begin
               // Divider is frozen here for the whole frame.
               w_state_nxt = ST_HALF;
               w_div_nxt   = w_div_live;
               w_cnt_nxt   = w_div_live >> 1;
            end else if (r_cnt == '0) begin
               o_bit_tick = 1'b1;
               w_cnt_nxt  = w_div_live;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         ST_HALF, ST_BIT: begin
            // Strobe is gated by the live request so a dropped request never
            // produces a late strobe.
            if (!w_run) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == '0) begin
               o_rx_strb   = 1'b1;
               w_state_nxt = ST_BIT;
               w_cnt_nxt   = r_div;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive control: sample strobe, idle timeout, status/irq
// Purpose : top of the receive control path; instantiates uart_baud_strobe and
//           holds the idle timeout counter, sticky W1C status and interrupt.
// Ports   : clk, rst (async, active-high); bus (uart_rx_ctrl_if.slave) carrying
//           enable/divider/timeout config, strobe request/strobe, FIFO flags and
//           read, error pulses, status clear, irq mask, status and irq.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int DIV_WIDTH     = 16,
   parameter int TIMEOUT_WIDTH = 8
) (
   input logic           clk,
   input logic           rst,
   uart_rx_ctrl_if.slave bus
);

   logic                     w_bit_tick;
   logic [TIMEOUT_WIDTH-1:0] r_tcnt;
   logic                     w_tcnt_clr;
   logic                     w_tcnt_inc;
   logic                     w_timeout_hit;
   logic [STAT_WIDTH-1:0]    r_status;
   logic [STAT_WIDTH-1:0]    w_set;
   logic [STAT_WIDTH-1:0]    w_live;
   logic [STAT_WIDTH-1:0]    w_status_nxt;
   logic                     r_irq;

   uart_baud_strobe #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_baud_strobe (
      .clk          (clk),
      .rst          (rst),
      .i_enable     (bus.i_enable),
      .i_baud_div   (bus.i_baud_div),
      .i_rx_strb_en (bus.i_rx_strb_en),
      .o_rx_strb    (bus.o_rx_strb),
      .o_bit_tick   (w_bit_tick)
   );

   // Timeout only counts while data sits unread in the FIFO and the line is idle.
   assign w_tcnt_clr    = bus.i_fifo_empty | bus.i_rx_strb_en | bus.i_fifo_rd_en | ~bus.i_enable;
   assign w_tcnt_inc    = ~w_tcnt_clr & w_bit_tick & (r_tcnt < bus.i_timeout);
   // Fires only on the increment that lands on the threshold; saturation then
   // blocks re-firing until the counter is cleared.
   assign w_timeout_hit = w_tcnt_inc & ((r_tcnt + 1'b1) == bus.i_timeout);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tcnt <= '0;
      end else if (w_tcnt_clr) begin
         r_tcnt <= '0;
      end else if (w_tcnt_inc) begin
         r_tcnt <= r_tcnt + 1'b1;
      end
   end

   always_comb begin
      w_set                 = '0;
      w_set[STAT_TIMEOUT]   = w_timeout_hit;
      w_set[STAT_PARITY]    = bus.i_parity_error;
      w_set[STAT_FRAME]     = bus.i_frame_error;
      w_set[STAT_OVERFLOW]  = bus.i_overflow_error;
      w_set[STAT_UNDERFLOW] = bus.i_underflow_error;

      w_live                 = '0;
      w_live[STAT_NOT_EMPTY] = ~bus.i_fifo_empty;
      w_live[STAT_FULL]      = bus.i_fifo_full;

      // Set is ORed after the clear so a coincident set wins.
      w_status_nxt = (w_live & ~STAT_STICKY_MASK)
                   | ((w_set | (r_status & ~bus.i_status_clr)) & STAT_STICKY_MASK);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_status <= '0;
         r_irq    <= 1'b0;
      end else begin
         r_status <= w_status_nxt;
         r_irq    <= |(r_status & bus.i_irq_mask);
      end
   end

   assign bus.o_status = r_status;
   assign bus.o_irq    = r_irq;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   cyc;
   int   strb_q[$];
   int   exp_q[$];
   int   c0;

   uart_rx_ctrl_if #(.DIV_WIDTH(16), .TIMEOUT_WIDTH(8)) bus ();

   uart_rx_ctrl #(.DIV_WIDTH(16), .TIMEOUT_WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   always @(negedge clk) begin
      if (bus.o_rx_strb === 1'b1) strb_q.push_back(cyc);
   end

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_strobes(input string tag, input int base, input int exp[$]);
      chk({tag, "_count"}, strb_q.size(), exp.size());
      for (int i = 0; i < exp.size(); i++) begin
         if (i < strb_q.size()) chk($sformatf("%s_s%0d", tag, i), strb_q[i] - base, exp[i]);
         else                   chk($sformatf("%s_s%0d", tag, i), -1, exp[i]);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.i_enable          = 1'b0;
      bus.i_baud_div        = 16'd15;
      bus.i_timeout         = 8'd0;
      bus.i_rx_strb_en      = 1'b0;
      bus.i_fifo_empty      = 1'b1;
      bus.i_fifo_full       = 1'b0;
      bus.i_fifo_rd_en      = 1'b0;
      bus.i_parity_error    = 1'b0;
      bus.i_frame_error     = 1'b0;
      bus.i_overflow_error  = 1'b0;
      bus.i_underflow_error = 1'b0;
      bus.i_status_clr      = 7'd0;
      bus.i_irq_mask        = 7'd0;
      step(3);
      @(negedge clk);
      chk("rst_strb", bus.o_rx_strb, 0);
      chk("rst_status", bus.o_status, 0);
      chk("rst_irq", bus.o_irq, 0);
      step(1);
      rst = 1'b0;
      step(2);
      @(negedge clk);
      chk("post_rst_status", bus.o_status, 0);

      // div=15: strobes 8 after request then every 16, none once request drops
      step(1);
      bus.i_enable = 1'b1;
      step(2);
      strb_q.delete();
      bus.i_rx_strb_en = 1'b1;
      c0 = cyc;
      step(120);
      bus.i_rx_strb_en = 1'b0;
      step(30);
      exp_q = '{8, 24, 40, 56, 72, 88, 104};
      check_strobes("div15", c0, exp_q);

      // div=1 clamps to 3: first strobe after 2, then every 4
      strb_q.delete();
      bus.i_baud_div = 16'd1;
      step(2);
      bus.i_rx_strb_en = 1'b1;
      c0 = cyc;
      step(20);
      bus.i_rx_strb_en = 1'b0;
      step(10);
      exp_q = '{2, 6, 10, 14, 18};
      check_strobes("div1", c0, exp_q);

      // divider change mid-frame is ignored until the next frame
      strb_q.delete();
      bus.i_baud_div = 16'd15;
      step(2);
      bus.i_rx_strb_en = 1'b1;
      c0 = cyc;
      step(10);
      bus.i_baud_div = 16'd7;
      step(40);
      bus.i_rx_strb_en = 1'b0;
      step(5);
      exp_q = '{8, 24, 40};
      check_strobes("divchg_a", c0, exp_q);
      strb_q.delete();
      bus.i_rx_strb_en = 1'b1;
      c0 = cyc;
      step(22);
      bus.i_rx_strb_en = 1'b0;
      step(10);
      exp_q = '{4, 12, 20};
      check_strobes("divchg_b", c0, exp_q);

      // reset asserted in BIT state on a strobe cycle
      bus.i_baud_div   = 16'd15;
      bus.i_fifo_empty = 1'b0;
      bus.i_irq_mask   = 7'b000_0001;
      step(3);
      @(negedge clk);
      chk("mask_irq", bus.o_irq, 1);
      step(1);
      strb_q.delete();
      bus.i_rx_strb_en = 1'b1;
      c0 = cyc;
      step(24);
      rst = 1'b1;
      #1;
      chk("midrst_strb", bus.o_rx_strb, 0);
      chk("midrst_status", bus.o_status, 0);
      chk("midrst_irq", bus.o_irq, 0);
      bus.i_rx_strb_en = 1'b0;
      step(2);
      rst = 1'b0;
      step(20);
      exp_q = '{8};
      check_strobes("midrst", c0, exp_q);
      strb_q.delete();
      bus.i_rx_strb_en = 1'b1;
      c0 = cyc;
      step(12);
      bus.i_rx_strb_en = 1'b0;
      step(5);
      check_strobes("postrst", c0, exp_q);

      // idle timeout: div=9, threshold 3 bit periods
      bus.i_irq_mask   = 7'd0;
      bus.i_enable     = 1'b0;
      bus.i_baud_div   = 16'd9;
      bus.i_timeout    = 8'd3;
      bus.i_status_clr = 7'h7C;
      step(1);
      bus.i_status_clr = 7'd0;
      step(2);
      bus.i_enable = 1'b1;
      c0 = cyc;
      step(20);
      @(negedge clk);
      chk("to_before", bus.o_status[2], 0);
      step(1);
      @(negedge clk);
      chk("to_fire", bus.o_status[2], 1);
      step(1);
      bus.i_status_clr = 7'b000_0100;
      step(1);
      bus.i_status_clr = 7'd0;
      step(25);
      @(negedge clk);
      chk("to_norefire", bus.o_status[2], 0);
      step(1);
      bus.i_enable = 1'b0;
      step(2);
      bus.i_enable = 1'b1;
      c0 = cyc;
      step(15);
      bus.i_fifo_rd_en = 1'b1;
      step(1);
      bus.i_fifo_rd_en = 1'b0;
      step(5);
      @(negedge clk);
      chk("to_rd_21", bus.o_status[2], 0);
      step(19);
      @(negedge clk);
      chk("to_rd_40", bus.o_status[2], 0);
      step(1);
      @(negedge clk);
      chk("to_rd_41", bus.o_status[2], 1);

      // sticky error bits, W1C, irq latency
      step(1);
      bus.i_irq_mask   = 7'b001_0000;
      bus.i_status_clr = 7'h7F;
      step(1);
      bus.i_status_clr = 7'd0;
      step(1);
      bus.i_frame_error = 1'b1;
      @(negedge clk);
      chk("fe_n0", bus.o_status[4], 0);
      step(1);
      bus.i_frame_error = 1'b0;
      @(negedge clk);
      chk("fe_n1_stat", bus.o_status[4], 1);
      chk("fe_n1_irq", bus.o_irq, 0);
      step(1);
      @(negedge clk);
      chk("fe_n2_irq", bus.o_irq, 1);
      step(1);
      bus.i_status_clr = 7'b001_0000;
      step(1);
      bus.i_status_clr = 7'd0;
      @(negedge clk);
      chk("clr_n1_stat", bus.o_status[4], 0);
      chk("clr_n1_irq", bus.o_irq, 1);
      step(1);
      @(negedge clk);
      chk("clr_n2_irq", bus.o_irq, 0);
      step(1);
      bus.i_frame_error = 1'b1;
      bus.i_status_clr  = 7'b001_0000;
      step(1);
      bus.i_frame_error = 1'b0;
      bus.i_status_clr  = 7'd0;
      @(negedge clk);
      chk("set_wins", bus.o_status[4], 1);
      step(1);
      bus.i_parity_error    = 1'b1;
      bus.i_overflow_error  = 1'b1;
      bus.i_underflow_error = 1'b1;
      step(1);
      bus.i_parity_error    = 1'b0;
      bus.i_overflow_error  = 1'b0;
      bus.i_underflow_error = 1'b0;
      bus.i_fifo_full       = 1'b1;
      step(1);
      @(negedge clk);
      chk("errs_all", bus.o_status[6:3], 15);
      step(1);
      bus.i_status_clr = 7'h7F;
      step(1);
      bus.i_status_clr = 7'd0;
      @(negedge clk);
      chk("clr_all_sticky", bus.o_status[6:2], 0);
      chk("clr_live_kept", bus.o_status[1:0], 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
